// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: sequential fetch, branch flush/redirect and CALL/RETURN handling.
// Define PREFETCH_RAS_EN to build the internal return-address stack and its ras_ovf/ras_unf outputs.
module prefetch_queue #(
   parameter int MINSTW = 8,
   parameter int NBOPCO = 6,
   parameter int NBOPER = 9,
   parameter int DEPTH  = 4,
   parameter int SDEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   output logic                     mem_en,
   output logic [MINSTW-1:0]        mem_addr,
   input  logic [NBOPCO+NBOPER-1:0] mem_data,
   output logic                     instr_valid,
   input  logic                     instr_ready,
   output logic [NBOPCO-1:0]        opcode,
   output logic [NBOPER-1:0]        operand,
   output logic [MINSTW-1:0]        instr_pc,
   input  logic                     cmp,
   output logic                     isp_push,
   output logic                     isp_pop,
   input  logic [MINSTW-1:0]        ret_addr,
   output logic [$clog2(DEPTH):0]   level
`ifdef PREFETCH_RAS_EN
   ,
   output logic                     ras_ovf,
   output logic                     ras_unf
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0]     FULL    = DEPTH[LW-1:0];
   localparam logic [NBOPCO-1:0] OP_JZ   = NBOPCO'(5);
   localparam logic [NBOPCO-1:0] OP_JMP  = NBOPCO'(6);
   localparam logic [NBOPCO-1:0] OP_CALL = NBOPCO'(7);
   localparam logic [NBOPCO-1:0] OP_RET  = NBOPCO'(8);

   // Field order matches mem_data ({opcode, operand}) followed by the fetch address.
   typedef struct packed {
      logic [NBOPCO-1:0] opc;
      logic [NBOPER-1:0] opr;
      logic [MINSTW-1:0] pc;
   } entry_t;

   entry_t              q_mem [DEPTH];
   entry_t              head;
   entry_t              hold_q;
   logic [AW-1:0]       rd_ptr_q;
   logic [AW-1:0]       wr_ptr_q;
   logic [LW-1:0]       level_q;
   logic [LW-1:0]       level_d;
   logic                inflight_q;
   logic [MINSTW-1:0]   inflight_pc_q;
   logic [MINSTW-1:0]   fpc_q;
   logic [MINSTW-1:0]   target;
   logic [MINSTW-1:0]   ret_target;
   logic                issue;
   logic                taken;
   logic                wr_en;
   logic                is_jz;
   logic                is_jmp;
   logic                is_call;
   logic                is_ret;

   assign head        = q_mem[rd_ptr_q];
   assign instr_valid = (level_q != '0);
   assign issue       = instr_valid & instr_ready;
   assign is_jz       = (head.opc == OP_JZ);
   assign is_jmp      = (head.opc == OP_JMP);
   assign is_call     = (head.opc == OP_CALL);
   assign is_ret      = (head.opc == OP_RET);
   assign taken       = issue & ((is_jz & ~cmp) | is_jmp | is_call | is_ret);
   assign target      = is_ret ? ret_target : head.opr[MINSTW-1:0];
   assign isp_push    = issue & is_call;
   assign isp_pop     = issue & is_ret;

   // Data returning in a flush cycle belongs to the wrong path and is dropped.
   assign wr_en    = inflight_q & ~taken;
   assign mem_en   = ~rst & ~taken & ((level_q + LW'(inflight_q)) < FULL);
   assign mem_addr = fpc_q;
   assign level    = level_q;
   assign {opcode, operand, instr_pc} = instr_valid ? head : hold_q;

   always_comb begin
      level_d = level_q + LW'(wr_en) - LW'(issue);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         level_q       <= '0;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
         fpc_q         <= '0;
         hold_q        <= '0;
      end else begin
         inflight_q <= mem_en;
         if (mem_en) begin
            inflight_pc_q <= fpc_q;
            fpc_q         <= fpc_q + MINSTW'(1);
         end
         if (issue) hold_q <= head;
         if (taken) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
            fpc_q    <= target;
         end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (issue) rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_d;
         end
      end
   end

   // NOTE: storage arrays carry no reset; the pointers and counts decide which entries are live.
   always_ff @(posedge clk) begin
      if (wr_en) q_mem[wr_ptr_q] <= {mem_data, inflight_pc_q};
   end

`ifdef PREFETCH_RAS_EN
   localparam int SW = $clog2(SDEPTH);
   localparam logic [SW:0] SFULL = SDEPTH[SW:0];

   logic [MINSTW-1:0] ras_mem [SDEPTH];
   logic [SW-1:0]     ras_top_q;
   logic [SW:0]       ras_cnt_q;
   logic              ras_ovf_q;
   logic              ras_unf_q;
   logic              ras_empty;
   logic              ras_full;

   assign ras_empty  = (ras_cnt_q == '0);
   assign ras_full   = (ras_cnt_q == SFULL);
   assign ret_target = ras_empty ? '0 : ras_mem[ras_top_q];
   assign ras_ovf    = ras_ovf_q;
   assign ras_unf    = ras_unf_q;

   // Circular stack: a push on a full stack lands on the oldest slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         ras_top_q <= '0;
         ras_cnt_q <= '0;
         ras_ovf_q <= 1'b0;
         ras_unf_q <= 1'b0;
      end else if (isp_push) begin
         ras_top_q <= ras_top_q + SW'(1);
         if (ras_full) ras_ovf_q <= 1'b1;
         else          ras_cnt_q <= ras_cnt_q + (SW+1)'(1);
      end else if (isp_pop) begin
         if (ras_empty) begin
            ras_unf_q <= 1'b1;
         end else begin
            ras_top_q <= ras_top_q - SW'(1);
            ras_cnt_q <= ras_cnt_q - (SW+1)'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (isp_push) ras_mem[ras_top_q + SW'(1)] <= head.pc + MINSTW'(1);
   end
`else
   assign ret_target = ret_addr;
`endif

endmodule

// File: doc/prefetch_queue.md
PREFETCH_QUEUE -- requirements
Module: prefetch_queue

Interface
REQ-001 SHALL have parameter MINSTW, default 8, instruction address width.
REQ-002 SHALL have parameter NBOPCO, default 6, opcode width.
REQ-003 SHALL have parameter NBOPER, default 9, operand width (>= MINSTW).
REQ-004 SHALL have parameter DEPTH, default 4, queue entries (power of 2, >= 2).
REQ-005 SHALL have parameter SDEPTH, default 8, return-stack entries (power of 2); used only with PREFETCH_RAS_EN.
REQ-006 SHALL have port clk, input, 1 bit, single clock, all state on rising edge.
REQ-007 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-008 SHALL have port mem_en, output, 1 bit, instruction-memory read strobe.
REQ-009 SHALL have port mem_addr, output, MINSTW bits, read address.
REQ-010 SHALL have port mem_data, input, NBOPCO+NBOPER bits, read data, valid exactly one cycle after mem_en.
REQ-011 SHALL have port instr_valid, output, 1 bit, queue head is valid.
REQ-012 SHALL have port instr_ready, input, 1 bit, core accepts head.
REQ-013 SHALL have ports opcode (NBOPCO), operand (NBOPER) and instr_pc (MINSTW), outputs, head fields and head address.
REQ-014 SHALL have port cmp, input, 1 bit, accumulator-nonzero flag, sampled when a JZ issues.
REQ-015 SHALL have ports isp_push and isp_pop, outputs, 1 bit each, one-cycle pulses on CALL/RETURN issue.
REQ-016 SHALL have port ret_addr, input, MINSTW bits, external return target (macro absent only).
REQ-017 SHALL have port level, output, clog2(DEPTH)+1 bits, valid entries held.

Function
REQ-018 Issue SHALL occur in a cycle with instr_valid=1 and instr_ready=1; opcode/operand/instr_pc SHALL be stable while instr_valid=1 and instr_ready=0.
REQ-019 mem_en SHALL be 1 when level plus reads in flight < DEPTH and no flush occurs this cycle; mem_addr SHALL equal fetch pointer fpc, and fpc SHALL increment modulo 2^MINSTW on each read.
REQ-020 Returned mem_data SHALL be written to the queue tail with its address; a same-cycle issue and write SHALL leave level unchanged.
REQ-021 Branch opcodes: 5 JZ (taken iff cmp=0), 6 JMP, 7 CALL, 8 RETURN; all others SHALL be non-branch.
REQ-022 A taken branch issue SHALL flush all queue entries, discard the read in flight (its data next cycle SHALL NOT be written), and set fpc to the target.
REQ-023 Target SHALL be operand[MINSTW-1:0] for JZ/JMP/CALL and the return address for RETURN.
REQ-024 The next mem_en after a taken branch SHALL be the cycle after issue with mem_addr=target; the first post-branch instr_valid SHALL occur two cycles after that read.
REQ-025 Untaken JZ SHALL behave as a non-branch, with no flush.
REQ-026 CALL SHALL pulse isp_push and push instr_pc+1 (mod 2^MINSTW); RETURN SHALL pulse isp_pop; the pulses SHALL occur in the issue cycle.
REQ-027 With an empty queue, instr_valid SHALL be 0 and outputs SHALL hold their last value.

Reset
REQ-028 When rst=1 at a clock edge: queue SHALL be emptied, level=0, fpc=0, in-flight read discarded, instr_valid=0, mem_en=0, isp_push=isp_pop=0, return stack emptied and flags cleared.
REQ-029 The first cycle with rst=0 SHALL assert mem_en with mem_addr=0; instr_valid SHALL rise two cycles later; rst asserted mid-operation SHALL take precedence over any issue or branch.

Configuration
REQ-030 Macro PREFETCH_RAS_EN SHALL compile in an internal SDEPTH-entry return-address stack, with outputs ras_ovf and ras_unf (1 bit each, sticky until reset).
REQ-031 With the macro: a CALL on a full stack SHALL overwrite the oldest entry and set ras_ovf; a RETURN on an empty stack SHALL target address 0 and set ras_unf; ret_addr SHALL be ignored.
REQ-032 Without the macro: no stack SHALL exist, the RETURN target SHALL be ret_addr sampled in the issue cycle, and ras_ovf/ras_unf SHALL be absent.

Verification
REQ-033 Reset, then memory holding non-branch words at 0..7 with instr_ready=1 -> instr_pc 0,1,2,... consecutively from the third cycle after reset, level never > DEPTH.
REQ-034 instr_ready=0 for 10 cycles, DEPTH=4 -> level saturates at 4, mem_en=0, head stays at address 0.
REQ-035 JMP 0x40 at address 3 -> next mem_addr=0x40, in-flight word 4 not issued, next issued instr_pc=0x40.
REQ-036 JZ 0x20 with cmp=1 -> no flush, next instr_pc=next sequential address; with cmp=0 -> next instr_pc=0x20.
REQ-037 With the macro, CALL 0x10 at 5, then RETURN -> isp_push pulse, then instr_pc 6; nine nested CALLs with SDEPTH=8 -> ras_ovf=1; RETURN on an empty stack -> target 0, ras_unf=1.
REQ-038 rst=1 asserted during a taken-branch issue -> next state is the reset state, and mem_addr=0 in the cycle after rst falls.
